// File: rtl/ram_fifo_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : fifo_pkg                                                      |
// | Description: Shared sizing constants and output-stage state type for the  |
// |              RAM-backed FIFO controller.                                   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package fifo_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int AF_TH  = 56;
  localparam int AE_TH  = 8;

  // IDLE: no word presented downstream; HOLD: RAM data_out carries a valid word
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } fifo_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_fifo_ctrl_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : fifo_ptr                                                      |
// | Description: ADDR_W-bit wrapping address counter with enable and          |
// |              asynchronous active-high reset.                               |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fifo_ptr #(
  parameter int ADDR_W = fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] c_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_ptr;

  // advance by one per enabled cycle; natural overflow gives the 63 -> 0 wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (enable) begin
      r_ptr <= r_ptr + c_ONE;
    end
  end

  assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : ram_fifo_ctrl                                                 |
// | Description: FIFO controller in front of a 64x16 single-clock RAM. Drives |
// |              the RAM write/read ports from a valid/ready push side and    |
// |              presents RAM data_out on a valid/ready pop side, hiding the  |
// |              RAM's one-cycle read latency.                                 |
// | Options    : FIFO_STATUS_EN adds almost_full/almost_empty/overflow/       |
// |              underflow outputs.                                            |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W,
  parameter int AF_TH  = fifo_pkg::AF_TH,
  parameter int AE_TH  = fifo_pkg::AE_TH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ram_wr_enable,
  output logic [ADDR_W-1:0] ram_wr_adress,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_rd_enable,
  output logic [ADDR_W-1:0] ram_rd_adress,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W:0]   count
`ifdef FIFO_STATUS_EN
  ,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W:0] c_DEPTH   = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] c_CNT_ONE = (ADDR_W+1)'(1);

  logic [ADDR_W-1:0] w_wr_ptr;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic [ADDR_W:0]   r_mem_cnt;
  logic [ADDR_W:0]   w_mem_cnt_next;
  fifo_state_t       r_state;
  fifo_state_t       w_state_next;
  logic              w_push;
  logic              w_pop;
  logic              w_fetch;

  // The word parked on RAM data_out counts toward capacity, so the FIFO
  // holds at most DEPTH words in total and count never exceeds DEPTH.
  assign count    = r_mem_cnt + {{ADDR_W{1'b0}}, out_valid};
  assign in_ready = (count != c_DEPTH);

  // enables are masked by reset so nothing reaches the RAM while it is held
  assign w_push  = in_valid & in_ready & ~reset;
  assign w_pop   = out_valid & out_ready;
  assign w_fetch = (r_mem_cnt != '0) & (~out_valid | out_ready) & ~reset;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk    (clk),
    .reset  (reset),
    .enable (w_push),
    .ptr    (w_wr_ptr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk    (clk),
    .reset  (reset),
    .enable (w_fetch),
    .ptr    (w_rd_ptr)
  );

  // output-stage state and RAM-resident word count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mem_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_mem_cnt <= w_mem_cnt_next;
    end
  end

  // next output state: a fetch loads data_out next cycle; a pop without a refill empties it
  always_comb begin
    w_state_next   = r_state;
    w_mem_cnt_next = r_mem_cnt;
    case (r_state)
      IDLE:    if (w_fetch) w_state_next = HOLD;
      HOLD:    if (w_pop && !w_fetch) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_push && !w_fetch) begin
      w_mem_cnt_next = r_mem_cnt + c_CNT_ONE;
    end else if (!w_push && w_fetch) begin
      w_mem_cnt_next = r_mem_cnt - c_CNT_ONE;
    end
  end

  // outputs: valid follows state; RAM ports driven from pointers and handshake
  always_comb begin
    out_valid     = (r_state == HOLD);
    ram_wr_enable = w_push;
    ram_wr_adress = w_wr_ptr;
    ram_rd_enable = w_fetch;
    ram_rd_adress = w_rd_ptr;
    ram_data_in   = in_data;
    out_data      = ram_data_out;
  end

`ifdef FIFO_STATUS_EN
  localparam logic [ADDR_W:0] c_AF_TH = (ADDR_W+1)'(AF_TH);
  localparam logic [ADDR_W:0] c_AE_TH = (ADDR_W+1)'(AE_TH);

  logic [ADDR_W:0] w_count_next;

  // thresholds are evaluated on next-cycle occupancy so the registered flags track count
  assign w_count_next = w_mem_cnt_next + {{ADDR_W{1'b0}}, (w_state_next == HOLD)};

  // registered level flags plus sticky error flags cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      almost_full  <= (w_count_next >= c_AF_TH);
      almost_empty <= (w_count_next <= c_AE_TH);
      overflow     <= overflow | (in_valid & ~in_ready);
      underflow    <= underflow | (out_ready & ~out_valid);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_ram_fifo_ctrl                                              |
// | Description: Directed self-checking bench for ram_fifo_ctrl with a        |
// |              behavioural 64x16 RAM and an in-order scoreboard.             |
// | Options    : FIFO_STATUS_EN enables the status-flag steps.                 |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        ram_wr_enable;
  logic [5:0]  ram_wr_adress;
  logic [15:0] ram_data_in;
  logic        ram_rd_enable;
  logic [5:0]  ram_rd_adress;
  logic [15:0] ram_data_out;
  logic [6:0]  count;
`ifdef FIFO_STATUS_EN
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [15:0] ram_mem [0:63];

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .ram_wr_enable (ram_wr_enable),
    .ram_wr_adress (ram_wr_adress),
    .ram_data_in   (ram_data_in),
    .ram_rd_enable (ram_rd_enable),
    .ram_rd_adress (ram_rd_adress),
    .ram_data_out  (ram_data_out),
    .count         (count)
`ifdef FIFO_STATUS_EN
    ,
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .overflow      (overflow),
    .underflow     (underflow)
`endif
  );

  // behavioural RAM: synchronous write, registered read that holds when not enabled
  always @(posedge clk) begin
    if (ram_wr_enable) ram_mem[ram_wr_adress] <= ram_data_in;
    if (ram_rd_enable) ram_data_out <= ram_mem[ram_rd_adress];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: record handshakes at the negedge, then advance past the posedge
  task automatic tick();
    logic [15:0] exp_word;
    @(negedge clk);
    if (in_valid && in_ready) sb.push_back(in_data);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("pop_with_empty_scoreboard", 32'(out_valid & out_ready), 32'd0);
      end else begin
        exp_word = sb.pop_front();
        check("pop_data", 32'(out_data), 32'(exp_word));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((count != 7'd0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_empty_count", 32'(count), 32'd0);
    check("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    out_ready = 1'b0;
    #3;
    // reset state, with in_valid high to confirm the write port is masked
    check("rst_wr_enable", 32'(ram_wr_enable), 32'd0);
    check("rst_rd_enable", 32'(ram_rd_enable), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_rel_in_ready", 32'(in_ready), 32'd1);

    // step 1: fill with out_ready low
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0100 + i);
      tick();
    end
    check("t1_count_full", 32'(count), 32'd64);
    check("t1_in_ready_low", 32'(in_ready), 32'd0);
    in_data = 16'hDEAD;
    check("t1_no_write_when_full", 32'(ram_wr_enable), 32'd0);
    check("t1_wr_ptr_wrapped", 32'(ram_wr_adress), 32'd0);
    tick();
    check("t1_count_held", 32'(count), 32'd64);
    check("t1_wr_ptr_held", 32'(ram_wr_adress), 32'd0);
    drain();

    // step 2: 0x0001..0x0040 in, then full-rate drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0001;
    tick();
    check("t2_lat_n1_valid", 32'(out_valid), 32'd0);
    in_data = 16'h0002;
    tick();
    check("t2_lat_n2_valid", 32'(out_valid), 32'd1);
    check("t2_lat_n2_data", 32'(out_data), 32'h0001);
    for (int i = 3; i <= 64; i++) begin
      in_data = 16'(i);
      tick();
    end
    check("t2_count_full", 32'(count), 32'd64);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check("t2_one_per_cycle", 32'(out_valid), 32'd1);
      tick();
    end
    check("t2_end_count", 32'(count), 32'd0);
    check("t2_end_valid", 32'(out_valid), 32'd0);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // step 3: streaming push+pop across pointer wrap
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_data = 16'(16'h1000 + i);
      tick();
      check("t3_count_1_to_2", 32'(count >= 7'd1 && count <= 7'd2), 32'd1);
    end
    drain();

    // step 4: stalled output with pushes continuing
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hABCD;
    tick();
    in_data = 16'h4000;
    tick();
    check("t4_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("t4_data_stable", 32'(out_data), 32'hABCD);
      check("t4_no_fetch", 32'(ram_rd_enable), 32'd0);
      in_data = 16'(16'h4001 + k);
      tick();
    end
    check("t4_data_stable_end", 32'(out_data), 32'hABCD);
    drain();

    // step 5: asynchronous reset with 30 words held
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h2000 + i);
      tick();
    end
    check("t5_count_30", 32'(count), 32'd30);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_wr_en", 32'(ram_wr_enable), 32'd0);
    check("t5_async_rd_en", 32'(ram_rd_enable), 32'd0);
    check("t5_async_count", 32'(count), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    check("t5_lat_n1_valid", 32'(out_valid), 32'd0);
    tick();
    check("t5_lat_n2_valid", 32'(out_valid), 32'd1);
    check("t5_lat_n2_data", 32'(out_data), 32'h1234);
    drain();

`ifdef FIFO_STATUS_EN
    // step 6: status flags
    out_ready = 1'b0;
    in_valid  = 1'b0;
    do_reset();
    check("t6_rst_ae", 32'(almost_empty), 32'd1);
    check("t6_rst_af", 32'(almost_full), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    check("t6_rst_udf", 32'(underflow), 32'd0);
    for (int i = 1; i <= 64; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h3000 + i);
      tick();
      check("t6_count", 32'(count), 32'(i));
      check("t6_almost_empty", 32'(almost_empty), 32'(i <= 8));
      check("t6_almost_full", 32'(almost_full), 32'(i >= 56));
    end
    check("t6_ovf_before", 32'(overflow), 32'd0);
    tick();
    check("t6_ovf_set", 32'(overflow), 32'd1);
    drain();
    check("t6_udf_before", 32'(underflow), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("t6_udf_sticky", 32'(underflow), 32'd1);
    check("t6_ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    check("t6_ovf_cleared", 32'(overflow), 32'd0);
    check("t6_udf_cleared", 32'(underflow), 32'd0);
`else
    do_reset();
    check("final_reset_count", 32'(count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
